mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bridge_pkg.sv | 6 +
 rtl/mem_bus_bridge_if.sv | 19 +
 rtl/mem_lane_align.sv | 18 +
 rtl/mem_bus_bridge.sv | 107 ++++++++++
 tb/tb_mem_bus_bridge.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared FSM states, access-width encodings and timeout read value for the memory bridge.
package mem_bridge_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  typedef enum logic {RW_WORD = 1'b0, RW_BYTE = 1'b1} rw_t;
  localparam logic [31:0] TIMEOUT_VALUE = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: word-wide memory bus; master is the bridge, slave is the memory.
interface mem_bus_bridge_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rvalid, bus_rdata
  );
  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication and zero-extended load extraction.
module mem_lane_align
  import mem_bridge_pkg::*;
(
  input  rw_t         rw_type,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic byte_acc;
  assign byte_acc = rw_type == RW_BYTE;
  assign be       = byte_acc ? 4'b0001 << lane : 4'b1111;
  assign wdata    = byte_acc ? {4{wdata_in[7:0]}} : wdata_in;
  assign rdata    = byte_acc ? {24'b0, rdata_in[{lane, 3'b000} +: 8]} : rdata_in;
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: pipeline load/store to memory-bus bridge; MEM_BRIDGE_TIMEOUT_EN adds an access timeout.
module mem_bus_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        MemRW,
  input  logic        RWType,
  input  logic [31:0] addr_out,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        mem_err,
  mem_bus_bridge_if.master bus
);
  state_t      state;
  rw_t         type_q;
  logic [1:0]  lane_q;
  rw_t         sel_type;
  logic [1:0]  sel_lane;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        aligned;
  logic        expired;
  assign aligned   = RWType == RW_BYTE || addr_out[1:0] == 2'b00;
  assign mem_stall = state == IDLE ? req_valid && aligned : state == REQ || state == RSP;
  // Lane logic sees the live request while idle, the latched one afterwards.
  assign sel_type  = state == IDLE ? rw_t'(RWType) : type_q;
  assign sel_lane  = state == IDLE ? addr_out[1:0] : lane_q;
  mem_lane_align u_lane (
    .rw_type (sel_type),
    .lane    (sel_lane),
    .wdata_in(data_out),
    .rdata_in(bus.bus_rdata),
    .be      (be),
    .wdata   (wdata),
    .rdata   (rdata)
  );
`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [31:0] cnt;
  assign expired = cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || state == IDLE) ? 32'd0 : cnt + 32'd1;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      type_q        <= RW_WORD;
      lane_q        <= 2'b00;
      data_in       <= 32'd0;
      mem_done      <= 1'b0;
      mem_err       <= 1'b0;
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
      bus.bus_be    <= 4'd0;
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (aligned) begin
            state         <= REQ;
            type_q        <= rw_t'(RWType);
            lane_q        <= addr_out[1:0];
            bus.bus_valid <= 1'b1;
            bus.bus_we    <= MemRW;
            bus.bus_addr  <= {addr_out[31:2], 2'b00};
            bus.bus_wdata <= wdata;
            bus.bus_be    <= be;
          end else
            mem_err <= 1'b1;
        end
        REQ: if (bus.bus_ready) begin
          bus.bus_valid <= 1'b0;
          state         <= bus.bus_we ? DONE : RSP;
          mem_done      <= bus.bus_we;
        end else if (expired) begin
          bus.bus_valid <= 1'b0;
          state         <= DONE;
          mem_done      <= 1'b1;
          mem_err       <= 1'b1;
          data_in       <= bus.bus_we ? data_in : TIMEOUT_VALUE;
        end
        RSP: if (bus.bus_rvalid) begin
          data_in  <= rdata;
          state    <= DONE;
          mem_done <= 1'b1;
        end else if (expired) begin
          data_in  <= TIMEOUT_VALUE;
          state    <= DONE;
          mem_done <= 1'b1;
          mem_err  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed and randomized accesses checked against a behavioural bridge model.
module tb_mem_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        MemRW = 1'b0;
  logic        RWType = 1'b0;
  logic [31:0] addr_out = 32'd0;
  logic [31:0] data_out = 32'd0;
  logic [31:0] data_in;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_err;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_din = 32'd0;

  mem_bus_bridge_if bus ();

  mem_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .MemRW    (MemRW),
    .RWType   (RWType),
    .addr_out (addr_out),
    .data_out (data_out),
    .data_in  (data_in),
    .mem_stall(mem_stall),
    .mem_done (mem_done),
    .mem_err  (mem_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int rdy, input int rv);
    logic        mis;
    logic [31:0] e_addr, e_be, e_wd;
    mis    = !bt && a[1:0] != 2'b00;
    e_addr = a & ~32'h3;
    e_be   = bt ? 32'h1 << a[1:0] : 32'hF;
    e_wd   = bt ? {24'd0, d[7:0]} * 32'h0101_0101 : d;
    req_valid = 1'b1; MemRW = we; RWType = bt; addr_out = a; data_out = d;
    #1 check("stall_req", {31'd0, mem_stall}, {31'd0, !mis});
    step();
    if (mis) begin
      req_valid = 1'b0;
      check("mis_err", {31'd0, mem_err}, 32'd1);
      check("mis_valid", {31'd0, bus.bus_valid}, 32'd0);
      check("mis_din", data_in, exp_din);
      step();
      check("mis_err_pulse", {31'd0, mem_err}, 32'd0);
      check("mis_valid2", {31'd0, bus.bus_valid}, 32'd0);
      return;
    end
    req_valid = 1'($urandom_range(0, 1));
    addr_out  = $urandom;
    check("req_valid", {31'd0, bus.bus_valid}, 32'd1);
    check("req_we", {31'd0, bus.bus_we}, {31'd0, we});
    check("req_addr", bus.bus_addr, e_addr);
    check("req_be", {28'd0, bus.bus_be}, e_be);
    check("req_wdata", bus.bus_wdata, e_wd);
    for (int i = 0; i < rdy; i++) begin
      bus.bus_rvalid = 1'($urandom_range(0, 1));
      bus.bus_rdata  = $urandom;
      step();
      check("hold_valid", {31'd0, bus.bus_valid}, 32'd1);
      check("hold_addr", bus.bus_addr, e_addr);
      check("hold_done", {31'd0, mem_done}, 32'd0);
      check("hold_din", data_in, exp_din);
    end
    bus.bus_rvalid = 1'b0;
    bus.bus_ready  = 1'b1;
    step();
    bus.bus_ready = 1'b0;
    check("acc_valid_low", {31'd0, bus.bus_valid}, 32'd0);
    if (!we) begin
      check("rsp_stall", {31'd0, mem_stall}, 32'd1);
      for (int i = 0; i < rv; i++) begin
        step();
        check("rsp_wait_done", {31'd0, mem_done}, 32'd0);
      end
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = rd;
      step();
      bus.bus_rvalid = 1'b0;
      exp_din = bt ? (rd >> (8 * a[1:0])) & 32'hFF : rd;
    end
    req_valid = 1'b0;
    check("done", {31'd0, mem_done}, 32'd1);
    check("done_err", {31'd0, mem_err}, 32'd0);
    check("done_stall", {31'd0, mem_stall}, 32'd0);
    check("done_din", data_in, exp_din);
    step();
    check("done_pulse", {31'd0, mem_done}, 32'd0);
    check("idle_din", data_in, exp_din);
  endtask

  initial begin
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
    @(negedge clk);
    step();
    check("rst_valid", {31'd0, bus.bus_valid}, 32'd0);
    check("rst_be", {28'd0, bus.bus_be}, 32'd0);
    check("rst_din", data_in, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_done", {31'd0, mem_done}, 32'd0);
    rst_n = 1'b1;
    step();
    access(1'b0, 1'b0, 32'h100, 32'd0, 32'h1234_5678, 0, 0);
    access(1'b1, 1'b1, 32'h103, 32'hAB, 32'd0, 0, 0);
    access(1'b0, 1'b1, 32'h102, 32'd0, 32'hAABB_CCDD, 0, 0);
    access(1'b0, 1'b0, 32'h101, 32'd0, 32'd0, 0, 0);
    access(1'b1, 1'b0, 32'h200, 32'hCAFE_F00D, 32'd0, 2, 0);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    req_valid = 1'b1; MemRW = 1'b0; RWType = 1'b0; addr_out = 32'h300;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    bus.bus_ready = 1'b1;
    step();
    bus.bus_ready = 1'b0;
    rst_n = 1'b0;
    step();
    exp_din = 32'd0;
    check("rst_mid_valid", {31'd0, bus.bus_valid}, 32'd0);
    check("rst_mid_we", {31'd0, bus.bus_we}, 32'd0);
    check("rst_mid_addr", bus.bus_addr, 32'd0);
    check("rst_mid_wdata", bus.bus_wdata, 32'd0);
    check("rst_mid_be", {28'd0, bus.bus_be}, 32'd0);
    check("rst_mid_din", data_in, 32'd0);
    check("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_mid_done", {31'd0, mem_done}, 32'd0);
    check("rst_mid_err", {31'd0, mem_err}, 32'd0);
    rst_n = 1'b1;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h5555_AAAA;
    step();
    bus.bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drop_done", {31'd0, mem_done}, 32'd0);
      check("drop_din", data_in, 32'd0);
      step();
    end
    access(1'b0, 1'b1, 32'h401, 32'd0, 32'h1122_3344, 1, 1);
`ifdef MEM_BRIDGE_TIMEOUT_EN
    req_valid = 1'b1; MemRW = 1'b0; RWType = 1'b0; addr_out = 32'h500;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("to_wait", {31'd0, mem_done}, 32'd0);
      step();
    end
    check("to_pre_done", {31'd0, mem_done}, 32'd0);
    step();
    check("to_done", {31'd0, mem_done}, 32'd1);
    check("to_err", {31'd0, mem_err}, 32'd1);
    check("to_din", data_in, 32'hDEAD_BEEF);
    step();
    check("to_done_pulse", {31'd0, mem_done}, 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
